instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 16'h0000, giving the first fetch address after reset; bit 0 is ignored.
REQ-002 The block SHALL have parameter QDEPTH, default 2, giving the number of entries in the fetch queue; only the value 2 is supported.
REQ-003 clock  input  1  Single clock; all state updates on its rising edge.
REQ-004 reset  input  1  Synchronous, active-high reset.
REQ-005 iaddr  output  16  Fetch address to instruction memory; always even.
REQ-006 idata  input  16  Instruction word returned combinationally by instruction memory for the current iaddr, in the same cycle.
REQ-007 redirect  input  1  Branch/jump redirect request from the decode stage.
REQ-008 redirect_pc  input  16  Redirect target address; bit 0 is ignored.
REQ-009 inst  output  16  Instruction at the queue head.
REQ-010 inst_pc  output  16  Address of the instruction on inst.
REQ-011 inst_valid  output  1  High when inst and inst_pc hold a valid queue-head entry.
REQ-012 inst_ready  input  1  Consumer accepts the queue head this cycle.

Function
REQ-013 The block SHALL keep a PC register and drive iaddr = {pc[15:1],1'b0} combinationally from that register.
REQ-014 A push SHALL occur in a cycle when redirect=0 and the queue is not full, or the queue is full and a pop occurs in the same cycle.
REQ-015 A push SHALL write {iaddr, idata} into the queue and update pc to pc+2, modulo 2^16 (16'hFFFE wraps to 16'h0000).
REQ-016 A pop SHALL occur when inst_valid and inst_ready are both high, and SHALL remove the head entry.
REQ-017 The queue SHALL have occupancy states EMPTY (0), ONE (1) and FULL (2); each cycle, occupancy SHALL change by +1 for a push alone, -1 for a pop alone, and 0 for a push together with a pop.
REQ-018 When the queue is FULL and no pop occurs, pc SHALL hold its value and no entry SHALL be overwritten.
REQ-019 inst_valid SHALL equal (occupancy != EMPTY), driven from registers, with no combinational path from idata.
REQ-020 Fetch-to-output latency SHALL be 1 cycle: an instruction pushed at edge N is visible on inst from edge N onward when the queue was EMPTY.
REQ-021 While the queue is EMPTY, inst and inst_pc SHALL hold their last values.
REQ-022 When redirect=1, the block SHALL take priority over push: flush all entries, including the entry popped in that cycle, which counts as consumed.
REQ-023 When redirect=1, the block SHALL also set pc to {redirect_pc[15:1],1'b0} and perform no push that cycle.
REQ-024 inst_valid SHALL be 0 in the cycle after a redirect and SHALL rise one cycle later with inst_pc equal to the redirect target.
REQ-025 Back-to-back redirects SHALL each take effect; the last one wins, and no entry from an older target SHALL become valid.
REQ-026 With inst_ready held at 1 and no redirect, the block SHALL deliver one instruction per cycle with strictly sequential inst_pc values and no bubbles.

Reset
REQ-027 While reset=1, the block SHALL set pc=RESET_PC with bit 0 cleared, set occupancy to EMPTY, set inst_valid=0, and set inst and inst_pc to 16'h0000.
REQ-028 Reset SHALL override redirect, push and pop in the same cycle.
REQ-029 Reset asserted mid-operation SHALL discard all queued entries, so that inst_valid=0 in the next cycle.
REQ-030 The first push after reset SHALL occur at the first edge where reset=0, with iaddr=RESET_PC.

Structure
REQ-031 The shared package SHALL hold: instruction width (16), address width (16), the default for RESET_PC, QDEPTH, and the occupancy-state encoding (EMPTY, ONE, FULL).
REQ-032 The block SHALL contain one sub-module, fetch_queue: a 2-entry synchronous FIFO of {pc,inst} with push, pop, flush and occupancy outputs, built with no memory inference.
REQ-033 PC update and push/pop/flush control logic SHALL reside in instr_fetch.

Verification
REQ-034 Reset followed by inst_ready=1 -> first valid cycle shows inst=16'h6103 with inst_pc=0, next cycle inst=16'h0043 with inst_pc=2, then every cycle shows sequential pc with no gaps.
REQ-035 After reset, inst_ready=0 for 4 cycles -> occupancy reaches FULL after 2 cycles, iaddr then holds at 16'h0004 and inst stays 16'h6103; after release, inst_pc sequence is 0,2,4 with no duplicates.
REQ-036 Queue FULL with redirect=1 and redirect_pc=16'h0011 -> next cycle inst_valid=0 and iaddr=16'h0010; following cycle inst_valid=1 and inst_pc=16'h0010.
REQ-037 redirect_pc=16'hFFFE -> inst_pc sequence FFFE then 0000 (wrap-around), with no spurious valid between them.
REQ-038 Redirect and pop in the same cycle, plus two consecutive redirects to 16'h0020 then 16'h0040 -> no entry at pc 16'h0020 ever becomes valid; the first valid entry is at inst_pc=16'h0040.
REQ-039 Reset pulsed for 1 cycle while the queue is FULL -> next cycle inst_valid=0 and iaddr=RESET_PC, and the old entries never reappear.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instr_fetch_pkg;

    localparam int unsigned IW = 16;
    localparam int unsigned AW = 16;

    localparam logic [AW-1:0] RESET_PC_DEFAULT = 16'h0000;
    localparam int unsigned   QDEPTH_DEFAULT   = 2;

    // Queue occupancy; the numeric value is the entry count.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [IW-1:0] inst;
    } fetch_entry_t;

    localparam fetch_entry_t ENTRY_ZERO = '{pc: 16'h0000, inst: 16'h0000};

    // Instruction addresses are halfword aligned; bit 0 is forced low.
    function automatic logic [AW-1:0] align_pc(input logic [AW-1:0] a);
        return a & 16'hFFFE;
    endfunction

endpackage

// File: rtl/instr_fetch_queue.sv
// Two-entry fetch FIFO of {pc, inst} built from discrete registers.
// The head register keeps its last contents while the queue is empty so the
// consumer-facing outputs hold steady.
module fetch_queue
    import instr_fetch_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t push_entry,
    output fetch_entry_t head_entry,
    output logic         head_valid,
    output occ_e         occ
);

    occ_e         occ_r;
    occ_e         occ_n_s;
    fetch_entry_t head_r;
    fetch_entry_t head_n_s;
    fetch_entry_t tail_r;
    fetch_entry_t tail_n_s;
    logic         valid_r;

    // Occupancy state and storage registers; reset empties the queue and zeroes the head.
    always_ff @(posedge clock) begin
        if (reset) begin
            occ_r   <= OCC_EMPTY;
            head_r  <= ENTRY_ZERO;
            tail_r  <= ENTRY_ZERO;
            valid_r <= 1'b0;
        end else begin
            occ_r   <= occ_n_s;
            head_r  <= head_n_s;
            tail_r  <= tail_n_s;
            valid_r <= (occ_n_s != OCC_EMPTY);
        end
    end

    // Next occupancy and entry movement; flush drops everything, a pop from FULL shifts tail to head.
    always_comb begin
        occ_n_s  = occ_r;
        head_n_s = head_r;
        tail_n_s = tail_r;
        if (flush) begin
            occ_n_s = OCC_EMPTY;
        end else begin
            case (occ_r)
                OCC_EMPTY: begin
                    if (push) begin
                        head_n_s = push_entry;
                        occ_n_s  = OCC_ONE;
                    end else begin
                        occ_n_s  = OCC_EMPTY;
                    end
                end
                OCC_ONE: begin
                    if (push && pop) begin
                        head_n_s = push_entry;
                        occ_n_s  = OCC_ONE;
                    end else if (push) begin
                        tail_n_s = push_entry;
                        occ_n_s  = OCC_FULL;
                    end else if (pop) begin
                        occ_n_s  = OCC_EMPTY;
                    end else begin
                        occ_n_s  = OCC_ONE;
                    end
                end
                OCC_FULL: begin
                    if (pop && push) begin
                        head_n_s = tail_r;
                        tail_n_s = push_entry;
                        occ_n_s  = OCC_FULL;
                    end else if (pop) begin
                        head_n_s = tail_r;
                        occ_n_s  = OCC_ONE;
                    end else begin
                        occ_n_s  = OCC_FULL;
                    end
                end
                default: begin
                    occ_n_s = OCC_EMPTY;
                end
            endcase
        end
    end

    assign head_entry = head_r;
    assign head_valid = valid_r;
    assign occ        = occ_r;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, fetch control and a two-entry queue
// between instruction memory and decode. Redirects flush the queue and
// restart fetching at the target on the following cycle.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [AW-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned   QDEPTH   = QDEPTH_DEFAULT
)(
    input  logic          clock,
    input  logic          reset,
    output logic [AW-1:0] iaddr,
    input  logic [IW-1:0] idata,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    output logic [IW-1:0] inst,
    output logic [AW-1:0] inst_pc,
    output logic          inst_valid,
    input  logic          inst_ready
);

    // Only a depth of two is supported; it maps onto the FULL occupancy code.
    localparam occ_e OCC_LIMIT = occ_e'(QDEPTH[1:0]);

    logic [AW-1:0] pc_r;
    logic [AW-1:0] pc_n_s;
    logic          push_s;
    logic          pop_s;
    logic          full_s;
    occ_e          occ_s;
    fetch_entry_t  head_s;
    fetch_entry_t  push_entry_s;
    logic          head_valid_s;

    assign iaddr        = align_pc(pc_r);
    assign full_s       = (occ_s == OCC_LIMIT);
    assign push_entry_s = '{pc: iaddr, inst: idata};

    // Handshake decode: a redirect suppresses the push; a full queue pushes only alongside a pop.
    always_comb begin
        pop_s  = head_valid_s && inst_ready;
        push_s = 1'b0;
        if (redirect) begin
            push_s = 1'b0;
        end else if (!full_s) begin
            push_s = 1'b1;
        end else begin
            push_s = pop_s;
        end
    end

    // Next PC: redirect target wins, otherwise advance by one halfword per push.
    always_comb begin
        pc_n_s = pc_r;
        if (redirect) begin
            pc_n_s = align_pc(redirect_pc);
        end else if (push_s) begin
            pc_n_s = iaddr + 16'd2;
        end else begin
            pc_n_s = pc_r;
        end
    end

    // PC register; reset restarts fetching at the aligned reset vector.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_r <= align_pc(RESET_PC);
        end else begin
            pc_r <= pc_n_s;
        end
    end

    fetch_queue u_queue (
        .clock      (clock),
        .reset      (reset),
        .flush      (redirect),
        .push       (push_s),
        .pop        (pop_s),
        .push_entry (push_entry_s),
        .head_entry (head_s),
        .head_valid (head_valid_s),
        .occ        (occ_s)
    );

    assign inst       = head_s.inst;
    assign inst_pc    = head_s.pc;
    assign inst_valid = head_valid_s;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios followed by random
// redirect/ready/reset traffic, compared against a queue-level reference model.
module tb_instr_fetch;

    localparam logic [15:0] RST_PC = 16'h0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        inst_ready = 1'b0;
    logic [15:0] idata;
    logic [15:0] iaddr;
    logic [15:0] inst;
    logic [15:0] inst_pc;
    logic        inst_valid;

    always #5 clock = ~clock;

    // Instruction memory contents as a pure function of the address.
    function automatic logic [15:0] mem_f(input logic [15:0] a);
        if (a == 16'h0000) return 16'h6103;
        else if (a == 16'h0002) return 16'h0043;
        else return (a * 16'd40503) ^ 16'h5A3C;
    endfunction

    assign idata = mem_f(iaddr);

    instr_fetch #(.RESET_PC(RST_PC), .QDEPTH(2)) dut (
        .clock       (clock),
        .reset       (reset),
        .iaddr       (iaddr),
        .idata       (idata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready)
    );

    // Reference model: a bounded queue of {pc,inst}, a fetch pc and the last head shown.
    logic [31:0] mq[$];
    logic [31:0] sb[$];
    logic [15:0] mpc = RST_PC & 16'hFFFE;
    logic [31:0] mlast = 32'h0;

    logic        exp_valid = 1'b0;
    logic [15:0] exp_iaddr = 16'h0;
    logic [31:0] exp_head = 32'h0;
    bit          chk_en = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: publish current expectations, drive inputs, advance the model.
    task automatic cyc(input bit r, input bit rd, input logic [15:0] rp, input bit rdy);
        @(negedge clock);
        exp_valid   = (mq.size() != 0);
        exp_iaddr   = mpc;
        exp_head    = mlast;
        chk_en      = 1'b1;
        reset       = r;
        redirect    = rd;
        redirect_pc = rp;
        inst_ready  = rdy;
        if (r) begin
            mq.delete();
            mpc   = RST_PC & 16'hFFFE;
            mlast = 32'h0;
        end else begin
            if (mq.size() != 0 && rdy) sb.push_back(mq.pop_front());
            if (rd) begin
                mq.delete();
                mpc = rp & 16'hFFFE;
            end else if (mq.size() < 2) begin
                mq.push_back({mpc, mem_f(mpc)});
                mpc = mpc + 16'd2;
            end
            if (mq.size() != 0) mlast = mq[0];
        end
    endtask

    // Monitor: per-cycle state checks plus scoreboard pop on every consumed instruction.
    always @(negedge clock) begin
        logic [31:0] e;
        #2;
        if (chk_en) begin
            check("inst_valid", {31'h0, inst_valid}, {31'h0, exp_valid});
            check("iaddr", {16'h0, iaddr}, {16'h0, exp_iaddr});
            check("head", {inst_pc, inst}, exp_head);
            if (!reset && inst_valid && inst_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL consume: got pc %h inst %h expected no delivery", inst_pc, inst);
                end else begin
                    e = sb.pop_front();
                    check("consume", {inst_pc, inst}, e);
                end
            end
        end
    end

    initial begin
        // Reset, then stream with ready held high.
        cyc(1'b1, 1'b0, 16'h0000, 1'b0);
        cyc(1'b1, 1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 16'h0000, 1'b1);
        // Reset, stall four cycles, then release.
        cyc(1'b1, 1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 16'h0000, 1'b1);
        // Fill, redirect to an odd target while full.
        cyc(1'b0, 1'b0, 16'h0000, 1'b0);
        cyc(1'b0, 1'b0, 16'h0000, 1'b0);
        cyc(1'b0, 1'b1, 16'h0011, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 16'h0000, 1'b1);
        // Wrap-around from the top of the address space.
        cyc(1'b0, 1'b1, 16'hFFFE, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 16'h0000, 1'b1);
        // Redirect with pop in the same cycle, then a second redirect.
        cyc(1'b0, 1'b1, 16'h0020, 1'b1);
        cyc(1'b0, 1'b1, 16'h0040, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 16'h0000, 1'b1);
        // Single-cycle reset while full.
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 16'h0000, 1'b0);
        cyc(1'b1, 1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 16'h0000, 1'b1);
        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            cyc(($urandom_range(0, 63) == 0),
                ($urandom_range(0, 7) == 0),
                16'($urandom),
                ($urandom_range(0, 9) < 7));
        end
        @(negedge clock);
        chk_en = 1'b0;
        #3;
        check("scoreboard_drained", sb.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
